// File: rtl/axi_r_burst_buffer.sv
// AXI read-data channel FIFO with optional burst store-and-forward release.
// Define AXI_R_BURST_BUFFER_ERR_CNT_EN to build the SLVERR/DECERR beat counter.
module axi_r_burst_buffer #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6,
    parameter int DEPTH      = 8,
    parameter int STORE_FWD  = 0,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  slave_valid_i,
    input  logic [DATA_WIDTH-1:0] slave_data_i,
    input  logic [1:0]            slave_resp_i,
    input  logic [USER_WIDTH-1:0] slave_user_i,
    input  logic [ID_WIDTH-1:0]   slave_id_i,
    input  logic                  slave_last_i,
    output logic                  slave_ready_o,
    output logic                  master_valid_o,
    output logic [DATA_WIDTH-1:0] master_data_o,
    output logic [1:0]            master_resp_o,
    output logic [USER_WIDTH-1:0] master_user_o,
    output logic [ID_WIDTH-1:0]   master_id_o,
    output logic                  master_last_o,
    input  logic                  master_ready_i,
    output logic [CNT_W-1:0]      count_o,
    output logic [CNT_W-1:0]      bursts_o,
    output logic [15:0]           err_cnt_o
);
    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic [USER_WIDTH-1:0] user;
        logic                  last;
    } beat_t;

    beat_t            mem_q [DEPTH];
    beat_t            mem_d [DEPTH];
    beat_t            wr_beat;
    beat_t            head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] bursts_q, bursts_d;
    logic             push, pop, full, empty, release_ok;

    assign wr_beat = '{id: slave_id_i, data: slave_data_i, resp: slave_resp_i,
                       user: slave_user_i, last: slave_last_i};
    assign head    = mem_q[rd_ptr_q];

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Full override lets bursts longer than DEPTH drain instead of deadlocking.
    generate
        if (STORE_FWD != 0) begin : g_store_fwd
            assign release_ok = (bursts_q != '0) || full;
        end else begin : g_cut_through
            assign release_ok = 1'b1;
        end
    endgenerate

    assign slave_ready_o  = !full;
    assign master_valid_o = !empty && release_ok;
    assign push           = slave_valid_i && slave_ready_o;
    assign pop            = master_valid_o && master_ready_i;

    assign master_data_o = head.data;
    assign master_resp_o = head.resp;
    assign master_user_o = head.user;
    assign master_id_o   = head.id;
    assign master_last_o = head.last;
    assign count_o       = count_q;
    assign bursts_o      = bursts_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        bursts_d = bursts_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_beat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        case ({push && slave_last_i, pop && head.last})
            2'b10:   bursts_d = bursts_q + CNT_W'(1);
            2'b01:   bursts_d = bursts_q - CNT_W'(1);
            default: bursts_d = bursts_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bursts_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bursts_q <= bursts_d;
        end
    end

`ifdef AXI_R_BURST_BUFFER_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // resp[1] marks SLVERR/DECERR; the count saturates rather than wrapping.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (pop && head.resp[1] && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_r_burst_buffer.sv
// Directed bench: cut-through and store-and-forward buffers driven from a vector table.
module tb_axi_r_burst_buffer;
    localparam int NI = 3;
`ifdef AXI_R_BURST_BUFFER_ERR_CNT_EN
    localparam int ERR_EXP = 2;
`else
    localparam int ERR_EXP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NI-1:0] s_valid, s_last, s_ready, m_valid, m_ready, m_last;
    logic [63:0]   s_data [NI];
    logic [63:0]   m_data [NI];
    logic [1:0]    s_resp [NI];
    logic [1:0]    m_resp [NI];
    logic [5:0]    s_user [NI];
    logic [5:0]    m_user [NI];
    logic [3:0]    s_id   [NI];
    logic [3:0]    m_id   [NI];
    logic [15:0]   err    [NI];
    logic [3:0]    cnt0, bur0, cnt1, bur1;
    logic [2:0]    cnt2, bur2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // inst 0: cut-through depth 8; inst 1: store-fwd depth 8; inst 2: store-fwd depth 4
    axi_r_burst_buffer #(.DEPTH(8), .STORE_FWD(0)) u_ct8 (
        .clk_i(clk), .rst_i(rst),
        .slave_valid_i(s_valid[0]), .slave_data_i(s_data[0]), .slave_resp_i(s_resp[0]),
        .slave_user_i(s_user[0]), .slave_id_i(s_id[0]), .slave_last_i(s_last[0]),
        .slave_ready_o(s_ready[0]), .master_valid_o(m_valid[0]), .master_data_o(m_data[0]),
        .master_resp_o(m_resp[0]), .master_user_o(m_user[0]), .master_id_o(m_id[0]),
        .master_last_o(m_last[0]), .master_ready_i(m_ready[0]),
        .count_o(cnt0), .bursts_o(bur0), .err_cnt_o(err[0]));

    axi_r_burst_buffer #(.DEPTH(8), .STORE_FWD(1)) u_sf8 (
        .clk_i(clk), .rst_i(rst),
        .slave_valid_i(s_valid[1]), .slave_data_i(s_data[1]), .slave_resp_i(s_resp[1]),
        .slave_user_i(s_user[1]), .slave_id_i(s_id[1]), .slave_last_i(s_last[1]),
        .slave_ready_o(s_ready[1]), .master_valid_o(m_valid[1]), .master_data_o(m_data[1]),
        .master_resp_o(m_resp[1]), .master_user_o(m_user[1]), .master_id_o(m_id[1]),
        .master_last_o(m_last[1]), .master_ready_i(m_ready[1]),
        .count_o(cnt1), .bursts_o(bur1), .err_cnt_o(err[1]));

    axi_r_burst_buffer #(.DEPTH(4), .STORE_FWD(1)) u_sf4 (
        .clk_i(clk), .rst_i(rst),
        .slave_valid_i(s_valid[2]), .slave_data_i(s_data[2]), .slave_resp_i(s_resp[2]),
        .slave_user_i(s_user[2]), .slave_id_i(s_id[2]), .slave_last_i(s_last[2]),
        .slave_ready_o(s_ready[2]), .master_valid_o(m_valid[2]), .master_data_o(m_data[2]),
        .master_resp_o(m_resp[2]), .master_user_o(m_user[2]), .master_id_o(m_id[2]),
        .master_last_o(m_last[2]), .master_ready_i(m_ready[2]),
        .count_o(cnt2), .bursts_o(bur2), .err_cnt_o(err[2]));

    typedef struct {
        int          inst;
        bit          v;
        logic [63:0] d;
        logic [1:0]  r;
        bit          l;
        bit          mr;
        bit          e_mv;
        logic [63:0] e_d;
        bit          e_l;
        int          e_cnt;
        int          e_bur;
        bit          e_sr;
    } vec_t;

    vec_t tv[$];

    function automatic void add(int inst, bit v, logic [63:0] d, bit l, bit mr,
                                bit e_mv, logic [63:0] e_d, bit e_l, int e_cnt,
                                int e_bur, bit e_sr);
        vec_t t;
        t = '{inst: inst, v: v, d: d, r: 2'd0, l: l, mr: mr, e_mv: e_mv, e_d: e_d,
              e_l: e_l, e_cnt: e_cnt, e_bur: e_bur, e_sr: e_sr};
        tv.push_back(t);
    endfunction

    function automatic int get_cnt(int i);
        case (i)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    function automatic int get_bur(int i);
        case (i)
            0:       return int'(bur0);
            1:       return int'(bur1);
            default: return int'(bur2);
        endcase
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            s_valid[i] = 1'b0;
            s_data[i]  = '0;
            s_resp[i]  = '0;
            s_user[i]  = '0;
            s_id[i]    = '0;
            s_last[i]  = 1'b0;
            m_ready[i] = 1'b0;
        end
    endtask

    task automatic drive(int i, bit v, logic [63:0] d, logic [1:0] r, bit l, bit mr);
        s_valid[i] = v;
        s_data[i]  = d;
        s_resp[i]  = r;
        s_user[i]  = d[5:0];
        s_id[i]    = d[3:0];
        s_last[i]  = l;
        m_ready[i] = mr;
    endtask

    task automatic chk_reset_vals(string tag, int i);
        chk($sformatf("%s.mvalid", tag), 64'(m_valid[i]), 64'd0);
        chk($sformatf("%s.sready", tag), 64'(s_ready[i]), 64'd1);
        chk($sformatf("%s.count", tag), 64'(get_cnt(i)), 64'd0);
        chk($sformatf("%s.bursts", tag), 64'(get_bur(i)), 64'd0);
        chk($sformatf("%s.data", tag), m_data[i], 64'd0);
        chk($sformatf("%s.payload", tag), {m_resp[i], m_user[i], m_id[i], m_last[i]}, 64'd0);
        chk($sformatf("%s.err", tag), 64'(err[i]), 64'd0);
    endtask

    initial begin
        vec_t t;
        idle_all();

        // cut-through: 4 beats streamed with ready high
        add(0, 1, 1, 0, 1,  0, 0, 0, 0, 0, 1);
        add(0, 1, 2, 0, 1,  1, 1, 0, 1, 0, 1);
        add(0, 1, 3, 0, 1,  1, 2, 0, 1, 0, 1);
        add(0, 1, 4, 1, 1,  1, 3, 0, 1, 0, 1);
        add(0, 0, 0, 0, 1,  1, 4, 1, 1, 1, 1);
        add(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
        // fill to 8 with downstream stalled
        for (int i = 0; i < 8; i++) begin
            add(0, 1, 64'(16 + i), 0, 0, i > 0, 16, 0, i, 0, 1);
        end
        // full: pop with input offered, no bypass; then simultaneous push/pop
        add(0, 1, 99, 0, 1,  1, 16, 0, 8, 0, 0);
        add(0, 1, 99, 0, 1,  1, 17, 0, 7, 0, 1);
        add(0, 0, 0, 0, 0,   1, 18, 0, 7, 0, 1);
        add(0, 0, 0, 0, 1,   1, 18, 0, 7, 0, 1);
        add(0, 0, 0, 0, 1,   1, 19, 0, 6, 0, 1);
        add(0, 0, 0, 0, 0,   1, 20, 0, 5, 0, 1);
        // store-and-forward, depth 8: held until last
        add(1, 1, 1, 0, 1,  0, 0, 0, 0, 0, 1);
        add(1, 1, 2, 0, 1,  0, 0, 0, 1, 0, 1);
        add(1, 1, 3, 0, 1,  0, 0, 0, 2, 0, 1);
        add(1, 1, 4, 1, 1,  0, 0, 0, 3, 0, 1);
        add(1, 0, 0, 0, 1,  1, 1, 0, 4, 1, 1);
        add(1, 0, 0, 0, 1,  1, 2, 0, 3, 1, 1);
        add(1, 0, 0, 0, 1,  1, 3, 0, 2, 1, 1);
        add(1, 0, 0, 0, 1,  1, 4, 1, 1, 1, 1);
        add(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
        // store-and-forward, depth 4: 6-beat burst drains via full override
        add(2, 1, 'h31, 0, 1,  0, 0, 0, 0, 0, 1);
        add(2, 1, 'h32, 0, 1,  0, 0, 0, 1, 0, 1);
        add(2, 1, 'h33, 0, 1,  0, 0, 0, 2, 0, 1);
        add(2, 1, 'h34, 0, 1,  0, 0, 0, 3, 0, 1);
        add(2, 1, 'h35, 0, 1,  1, 'h31, 0, 4, 0, 0);
        add(2, 1, 'h35, 0, 1,  0, 0, 0, 3, 0, 1);
        add(2, 1, 'h36, 1, 1,  1, 'h32, 0, 4, 0, 0);
        add(2, 1, 'h36, 1, 1,  0, 0, 0, 3, 0, 1);
        add(2, 0, 0, 0, 1,     1, 'h33, 0, 4, 1, 0);
        add(2, 0, 0, 0, 1,     1, 'h34, 0, 3, 1, 1);
        add(2, 0, 0, 0, 1,     1, 'h35, 0, 2, 1, 1);
        add(2, 0, 0, 0, 1,     1, 'h36, 1, 1, 1, 1);
        add(2, 0, 0, 0, 1,     0, 0, 0, 0, 0, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk_reset_vals($sformatf("rst%0d", i), i);
        rst = 1'b0;

        foreach (tv[k]) begin
            t = tv[k];
            @(posedge clk);
            #1;
            idle_all();
            drive(t.inst, t.v, t.d, t.r, t.l, t.mr);
            @(negedge clk);
            chk($sformatf("v%0d.mvalid", k), 64'(m_valid[t.inst]), 64'(t.e_mv));
            chk($sformatf("v%0d.sready", k), 64'(s_ready[t.inst]), 64'(t.e_sr));
            chk($sformatf("v%0d.count", k), 64'(get_cnt(t.inst)), 64'(t.e_cnt));
            chk($sformatf("v%0d.bursts", k), 64'(get_bur(t.inst)), 64'(t.e_bur));
            if (t.e_mv) begin
                chk($sformatf("v%0d.data", k), m_data[t.inst], t.e_d);
                chk($sformatf("v%0d.last", k), 64'(m_last[t.inst]), 64'(t.e_l));
                chk($sformatf("v%0d.id", k), 64'(m_id[t.inst]), 64'(t.e_d[3:0]));
            end
        end

        // async reset with 5 beats held and valid high
        @(posedge clk);
        #1;
        idle_all();
        @(negedge clk);
        chk("prerst.mvalid", 64'(m_valid[0]), 64'd1);
        chk("prerst.count", 64'(get_cnt(0)), 64'd5);
        #2 rst = 1'b1;
        #1 chk_reset_vals("midrst", 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 drive(0, 1, 'hAB, 2'd0, 1, 1);
        @(negedge clk);
        chk("postrst.sready", 64'(s_ready[0]), 64'd1);
        chk("postrst.count0", 64'(get_cnt(0)), 64'd0);
        @(posedge clk);
        #1 drive(0, 0, 0, 2'd0, 0, 1);
        @(negedge clk);
        chk("postrst.mvalid", 64'(m_valid[0]), 64'd1);
        chk("postrst.data", m_data[0], 64'hAB);
        chk("postrst.last", 64'(m_last[0]), 64'd1);
        chk("postrst.count1", 64'(get_cnt(0)), 64'd1);
        chk("postrst.bursts", 64'(get_bur(0)), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("postrst.drained", 64'(get_cnt(0)), 64'd0);
        chk("postrst.mvalid0", 64'(m_valid[0]), 64'd0);

        // error responses 0,2,3,1 streamed through
        begin
            logic [1:0] rs [4];
            rs = '{2'd0, 2'd2, 2'd3, 2'd1};
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1 drive(0, 1, 64'(i + 1), rs[i], i == 3, 1);
            end
        end
        @(posedge clk);
        #1 drive(0, 0, 0, 2'd0, 0, 1);
        @(posedge clk);
        @(negedge clk);
        chk("err.count", 64'(err[0]), 64'(ERR_EXP));
        chk("err.drained", 64'(get_cnt(0)), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
